// File: rtl/dm_sync_be.sv
`default_nettype none
// ============================================================================
// Module      : dm_sync_be
// Description : Synchronous data memory with per-byte write enables, a
//               registered read with valid strobe, an out-of-range error
//               strobe and a sequential clear engine (after reset or on clr).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_sync_be #(
    parameter int DATA_WIDTH       = 16,
    parameter int DM_ADDRESS_WIDTH = 6,
    parameter int DEPTH            = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic [DATA_WIDTH/8-1:0]     be,
    input  logic [DM_ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]       D,
    input  logic                        clr,
    output logic                        ready,
    output logic [DATA_WIDTH-1:0]       Q,
    output logic                        rvalid,
    output logic                        busy,
    output logic                        err
);

    localparam int c_NB    = DATA_WIDTH / 8;
    localparam int c_CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0]        c_LAST    = c_CNT_W'(DEPTH - 1);
    // Depth widened by one bit so DEPTH == 2**DM_ADDRESS_WIDTH is representable
    localparam logic [DM_ADDRESS_WIDTH:0] c_DEPTH_X = (DM_ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]  r_q;
    logic                   r_rvalid;
    logic                   r_err;

    logic                   w_acc;
    logic                   w_inrange;
    logic [c_CNT_W-1:0]     w_idx;

    // Request qualification; clr and rst both block acceptance
    assign w_acc     = req & (r_state == S_IDLE) & ~clr & ~rst;
    assign w_inrange = ({1'b0, addr} < c_DEPTH_X);
    assign w_idx     = addr[c_CNT_W-1:0];

    // State and clear-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: walk the counter through the array, then idle until clr
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage: clear engine zeroes one word per cycle, otherwise byte-masked writes
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_acc && we && w_inrange) begin
            for (int i = 0; i < c_NB; i++) begin
                if (be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= D[8*i +: 8];
                end
            end
        end
    end

    // Registered read path with valid and out-of-range strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_acc & ~we;
            r_err    <= w_acc & ~w_inrange;
            if (w_acc && !we) begin
                r_q <= w_inrange ? r_mem[w_idx] : '0;
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = (r_state == S_CLEAR);
    assign Q      = r_q;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule
`default_nettype wire
